cpu_state_dumper: RTL

//  Hardware debug unit inside the pipelined MIPS CPU. Counts cycles, stalls and flushes.
//  On request, streams a snapshot of CPU state as a valid/ready stream of 32-bit words:
//  PC, the register file and the low data-memory words.

---
 rtl/cpu_dbg_pkg.sv | 37 +++
 rtl/dbg_stream_reg.sv | 35 +++
 rtl/cpu_state_dumper.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU state dumper.
// Record layout: 4 header words, then register file, then low data memory,
// optionally followed by an XOR trailer word (DUMP_CHECKSUM_EN).
package cpu_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_REG,
        ST_MEM,
        ST_CHK
    } dump_state_e;

    // Header word positions within a record
    localparam int W_STL    = 1;
    localparam int W_FLS    = 2;
    localparam int W_PC     = 3;
    localparam int HDR_LEN  = 4;
    localparam int REG_BASE = HDR_LEN;

    function automatic int rec_len(input int nr, input int nd);
        rec_len = HDR_LEN + nr + nd;
    endfunction

    // Phase that a given word index belongs to
    function automatic dump_state_e phase_of(input int idx, input int nr, input int nd);
        if (idx < REG_BASE)
            phase_of = ST_HDR;
        else if (idx < REG_BASE + nr)
            phase_of = ST_REG;
        else if (idx < REG_BASE + nr + nd)
            phase_of = ST_MEM;
        else
            phase_of = ST_CHK;
    endfunction

endpackage

// File: rtl/dbg_stream_reg.sv
// Single-entry valid/ready output register for the debug stream.
// Accepts a new word whenever it is empty or its current word is being taken.
module dbg_stream_reg #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic         can_load_o,
    output logic [W-1:0] tx_data_o,
    output logic         tx_valid_o,
    input  logic         tx_ready_i
);

    logic [W-1:0] data_q;
    logic         valid_q;

    assign can_load_o = !valid_q || tx_ready_i;
    assign tx_data_o  = data_q;
    assign tx_valid_o = valid_q;

    // Hold while stalled; otherwise take the offered word or go empty
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (can_load_o) begin
            valid_q <= load_i;
            if (load_i)
                data_q <= data_i;
        end
    end

endmodule

// File: rtl/cpu_state_dumper.sv
// CPU debug unit: cycle/stall/flush counters and a streamed state snapshot.
// Optional trailer word (XOR of the record) when DUMP_CHECKSUM_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no dump; snap_i starts a record and loads W0
// ST_HDR  | output register holds a header word (cyc/stl/fls/pc)
// ST_REG  | output register holds a register-file word
// ST_MEM  | output register holds a data-memory word
// ST_CHK  | output register holds the XOR trailer
module cpu_state_dumper
    import cpu_dbg_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_DMEM = 8,
    parameter int CNT_W    = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        snap_i,
    output logic [4:0]  rf_addr_o,
    input  logic [31:0] rf_data_i,
    output logic [31:0] dm_addr_o,
    input  logic [31:0] dm_data_i,
    output logic [31:0] tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o
);

    localparam int REC_LEN  = rec_len(NUM_REGS, NUM_DMEM);
    localparam int MEM_BASE = REG_BASE + NUM_REGS;
`ifdef DUMP_CHECKSUM_EN
    localparam int TOT_LEN  = REC_LEN + 1;
`else
    localparam int TOT_LEN  = REC_LEN;
`endif
    localparam int IDX_W    = $clog2(TOT_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOT_LEN - 1);

    logic [CNT_W-1:0] cyc_q, stl_q, fls_q;
    logic [31:0]      stl_snap_q, fls_snap_q, pc_snap_q;
    dump_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
    logic             take_snap;
    logic             load;
    logic             can_load;
    logic             xfer;
    logic [31:0]      next_word;
    logic [31:0]      load_word;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0]      chk_q;
`endif

    // idx_q is the word currently in the output register; nxt_idx is the one to fetch
    assign nxt_idx = idx_q + IDX_W'(1);
    assign xfer    = tx_valid_o && tx_ready_i;
    assign busy_o  = (state_q != ST_IDLE);

    // Performance counters, free-running while the CPU runs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_q <= '0;
            stl_q <= '0;
            fls_q <= '0;
        end else if (start_i) begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (stall_i)
                stl_q <= stl_q + CNT_W'(1);
            if (flush_i)
                fls_q <= fls_q + CNT_W'(1);
        end
    end

    // Freeze the remaining header words at the moment the dump is taken
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stl_snap_q <= '0;
            fls_snap_q <= '0;
            pc_snap_q  <= '0;
        end else if (take_snap) begin
            stl_snap_q <= 32'(stl_q);
            fls_snap_q <= 32'(fls_q);
            pc_snap_q  <= pc_i;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Running XOR of every word loaded into the output register this record
    always_ff @(posedge clk_i) begin
        if (rst_i)
            chk_q <= '0;
        else if (load)
            chk_q <= take_snap ? load_word : (chk_q ^ load_word);
    end
`endif

    // Read addresses point at the word that will be loaded on the next transfer
    always_comb begin
        rf_addr_o = '0;
        dm_addr_o = '0;
        if (state_q != ST_IDLE) begin
            if (int'(nxt_idx) >= REG_BASE && int'(nxt_idx) < MEM_BASE)
                rf_addr_o = 5'(int'(nxt_idx) - REG_BASE);
            if (int'(nxt_idx) >= MEM_BASE && int'(nxt_idx) < REC_LEN)
                dm_addr_o = 32'((int'(nxt_idx) - MEM_BASE) * 4);
        end
    end

    // Select the next record word by index
    always_comb begin
        next_word = '0;
        if (int'(nxt_idx) == W_STL)
            next_word = stl_snap_q;
        else if (int'(nxt_idx) == W_FLS)
            next_word = fls_snap_q;
        else if (int'(nxt_idx) == W_PC)
            next_word = pc_snap_q;
        else if (int'(nxt_idx) >= REG_BASE && int'(nxt_idx) < MEM_BASE)
            next_word = rf_data_i;
        else if (int'(nxt_idx) >= MEM_BASE && int'(nxt_idx) < REC_LEN)
            next_word = dm_data_i;
`ifdef DUMP_CHECKSUM_EN
        else if (int'(nxt_idx) == REC_LEN)
            next_word = chk_q;
`endif
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: advance one word per accepted transfer; a snap on the final
    // accept chains straight into a new record
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        load      = 1'b0;
        load_word = next_word;
        take_snap = 1'b0;
        case (state_q)
            ST_IDLE: begin
                take_snap = snap_i;
            end
            default: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d   = ST_IDLE;
                        idx_d     = '0;
                        take_snap = snap_i;
                    end else begin
                        load    = 1'b1;
                        idx_d   = nxt_idx;
                        state_d = phase_of(int'(nxt_idx), NUM_REGS, NUM_DMEM);
                    end
                end
            end
        endcase
        if (take_snap) begin
            load      = 1'b1;
            load_word = 32'(cyc_q);
            idx_d     = '0;
            state_d   = ST_HDR;
        end
    end

    dbg_stream_reg #(.W(32)) u_out (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (load),
        .data_i     (load_word),
        .can_load_o (can_load),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i)
    );

    // can_load is implied by the FSM (loads only in IDLE or on a transfer)
    logic unused_can_load;
    assign unused_can_load = can_load;

endmodule
